// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch FSM states and fetch constants.
package pipeline_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2,
        VALID = 2'd3
    } if_state_t;

    // addi x0,x0,0 -- shown to decode whenever no real instruction is held
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Byte distance between sequential instruction words
    localparam int PC_STEP = 4;

endpackage

// File: rtl/if_stage_if.sv
// Handshake bundles used by the fetch stage: fetch->decode and fetch->imem.

// Fetch-to-decode give/get handshake carrying instruction and its PC
interface if_id_if #(parameter int BITSIZE = 32);
    logic               IF_ID_give_o;
    logic               ID_IF_get_i;
    logic [31:0]        IF_ID_instr_o;
    logic [BITSIZE-1:0] IF_ID_pc_o;

    modport master (output IF_ID_give_o, output IF_ID_instr_o, output IF_ID_pc_o,
                    input  ID_IF_get_i);
    modport slave  (input  IF_ID_give_o, input  IF_ID_instr_o, input  IF_ID_pc_o,
                    output ID_IF_get_i);
endinterface

// Fetch-to-instruction-memory request/acknowledge bus
interface if_mem_if #(parameter int BITSIZE = 32);
    logic               IF_MEM_req_o;
    logic [BITSIZE-1:0] IF_MEM_addr_o;
    logic               MEM_IF_ack_i;
    logic [31:0]        MEM_IF_data_i;

    modport master (output IF_MEM_req_o, output IF_MEM_addr_o,
                    input  MEM_IF_ack_i, input  MEM_IF_data_i);
    modport slave  (input  IF_MEM_req_o, input  IF_MEM_addr_o,
                    output MEM_IF_ack_i, output MEM_IF_data_i);
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one fetch at a time, hands
// instructions to decode and squashes wrong-path fetches on redirects.
module if_stage #(
    parameter int                BITSIZE   = 32,
    parameter logic [BITSIZE-1:0] RESET_PC  = '0,
    parameter logic [31:0]       NOP_INSTR = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               resetn_i,
    if_id_if.master            id_bus,
    if_mem_if.master           mem_bus,
    input  logic               EX_IF_branch_i,
    input  logic [BITSIZE-1:0] EX_IF_target_i,
    output logic               misaligned_o
);
    import pipeline_pkg::*;

    if_state_t          state, state_n;
    logic [BITSIZE-1:0] fetch_addr, fetch_addr_n;
    logic [BITSIZE-1:0] pending_target, pending_target_n;
    logic [31:0]        instr, instr_n;
    logic               misaligned_n;
    logic [BITSIZE-1:0] eff_target;

    assign eff_target = {EX_IF_target_i[BITSIZE-1:2], 2'b00};

    assign mem_bus.IF_MEM_req_o  = (state == FETCH) || (state == FLUSH);
    assign mem_bus.IF_MEM_addr_o = fetch_addr;
    assign id_bus.IF_ID_pc_o     = fetch_addr;
    assign id_bus.IF_ID_instr_o  = instr;
    assign id_bus.IF_ID_give_o   = (state == VALID) && !EX_IF_branch_i;

    // State and datapath registers; reset abandons any in-flight fetch
    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            state          <= IDLE;
            fetch_addr     <= RESET_PC;
            pending_target <= RESET_PC;
            instr          <= NOP_INSTR;
            misaligned_o   <= 1'b0;
        end else begin
            state          <= state_n;
            fetch_addr     <= fetch_addr_n;
            pending_target <= pending_target_n;
            instr          <= instr_n;
            misaligned_o   <= misaligned_n;
        end
    end

    // Next-state logic: fetch sequencing, redirect capture and flush handling
    always_comb begin
        state_n          = state;
        fetch_addr_n     = fetch_addr;
        pending_target_n = pending_target;
        instr_n          = instr;
        misaligned_n     = EX_IF_branch_i && (EX_IF_target_i[1:0] != 2'b00);

        case (state)
            IDLE: begin
                state_n = FETCH;
            end
            FETCH: begin
                if (mem_bus.MEM_IF_ack_i && EX_IF_branch_i) begin
                    fetch_addr_n = eff_target;
                end else if (EX_IF_branch_i) begin
                    pending_target_n = eff_target;
                    state_n          = FLUSH;
                end else if (mem_bus.MEM_IF_ack_i) begin
                    instr_n = mem_bus.MEM_IF_data_i;
                    state_n = VALID;
                end
            end
            FLUSH: begin
                if (EX_IF_branch_i) begin
                    pending_target_n = eff_target;
                end
                if (mem_bus.MEM_IF_ack_i) begin
                    fetch_addr_n = EX_IF_branch_i ? eff_target : pending_target;
                    state_n      = FETCH;
                end
            end
            VALID: begin
                if (EX_IF_branch_i) begin
                    fetch_addr_n = eff_target;
                    instr_n      = NOP_INSTR;
                    state_n      = FETCH;
                end else if (id_bus.ID_IF_get_i) begin
                    fetch_addr_n = fetch_addr + BITSIZE'(PC_STEP);
                    instr_n      = NOP_INSTR;
                    state_n      = FETCH;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for the instruction-fetch stage.
module tb_if_stage;

    logic        clk;
    logic        resetn;
    logic        branch;
    logic [31:0] target;
    logic        misaligned;

    int assertCount;
    int failCount;

    if_id_if  #(.BITSIZE(32)) id_bus  ();
    if_mem_if #(.BITSIZE(32)) mem_bus ();

    if_stage #(
        .BITSIZE  (32),
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0013)
    ) dut (
        .clk           (clk),
        .resetn_i      (resetn),
        .id_bus        (id_bus),
        .mem_bus       (mem_bus),
        .EX_IF_branch_i(branch),
        .EX_IF_target_i(target),
        .misaligned_o  (misaligned)
    );

    // Free-running clock, 10 ns period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends
    initial begin
        #20000;
        $display("[TB] FAIL timeout: bench did not reach its end");
        $fatal(1, "[TB] timeout");
    end

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, then let outputs settle
    task automatic applyStimulus(input logic ack, input logic [31:0] data, input logic get,
                                 input logic br, input logic [31:0] tgt);
        @(negedge clk);
        mem_bus.MEM_IF_ack_i  = ack;
        mem_bus.MEM_IF_data_i = data;
        id_bus.ID_IF_get_i    = get;
        branch                = br;
        target                = tgt;
        #1;
    endtask

    // Check the full request/handoff picture of the current cycle
    task automatic checkCycle(input string tag, input logic req, input logic [31:0] addr,
                              input logic give, input logic [31:0] instr);
        checkOutput({tag, ".req"},   {31'd0, mem_bus.IF_MEM_req_o}, {31'd0, req});
        checkOutput({tag, ".addr"},  mem_bus.IF_MEM_addr_o, addr);
        checkOutput({tag, ".give"},  {31'd0, id_bus.IF_ID_give_o}, {31'd0, give});
        checkOutput({tag, ".instr"}, id_bus.IF_ID_instr_o, instr);
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        resetn      = 1'b0;
        branch      = 1'b0;
        target      = '0;
        mem_bus.MEM_IF_ack_i  = 1'b0;
        mem_bus.MEM_IF_data_i = '0;
        id_bus.ID_IF_get_i    = 1'b0;
        repeat (2) @(negedge clk);

        // Reset release: IDLE cycle, nothing requested
        resetn = 1'b1;
        #1;
        checkCycle("rst", 1'b0, 32'h0, 1'b0, 32'h13);
        checkOutput("rst.pc", id_bus.IF_ID_pc_o, 32'h0);
        checkOutput("rst.mis", {31'd0, misaligned}, 32'd0);

        // Cycle 1: zero-wait fetch of address 0
        applyStimulus(1'b1, 32'h0050_0093, 1'b1, 1'b0, 32'h0);
        checkCycle("c1", 1'b1, 32'h0, 1'b0, 32'h13);
        // Cycle 2: instruction handed to decode
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checkCycle("c2", 1'b0, 32'h0, 1'b1, 32'h0050_0093);
        checkOutput("c2.pc", id_bus.IF_ID_pc_o, 32'h0);
        // Cycle 3: sequential fetch of address 4
        applyStimulus(1'b1, 32'h00A0_0113, 1'b0, 1'b0, 32'h0);
        checkCycle("c3", 1'b1, 32'h4, 1'b0, 32'h13);

        // Decode stall: everything held for 5 cycles
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
            checkCycle("stall", 1'b0, 32'h4, 1'b1, 32'h00A0_0113);
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checkCycle("stall.go", 1'b0, 32'h4, 1'b1, 32'h00A0_0113);

        // Slow memory: redirect to 0x100 during the wait, old data dropped
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h100);
        checkCycle("slow0", 1'b1, 32'h8, 1'b0, 32'h13);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkCycle("slow1", 1'b1, 32'h8, 1'b0, 32'h13);
        applyStimulus(1'b1, 32'hBAD0_BAD0, 1'b1, 1'b0, 32'h0);
        checkCycle("slow2", 1'b1, 32'h8, 1'b0, 32'h13);
        applyStimulus(1'b1, 32'h1111_1111, 1'b1, 1'b0, 32'h0);
        checkCycle("redir", 1'b1, 32'h100, 1'b0, 32'h13);

        // Branch to 0x200 while VALID with get high: handoff suppressed
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h200);
        checkCycle("vbr", 1'b0, 32'h100, 1'b0, 32'h1111_1111);
        applyStimulus(1'b1, 32'h2222_2222, 1'b0, 1'b0, 32'h0);
        checkCycle("vbr.next", 1'b1, 32'h200, 1'b0, 32'h13);
        checkOutput("vbr.mis", {31'd0, misaligned}, 32'd0);

        // Misaligned redirect to 0x203 lands at 0x200 and flags one cycle later
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h203);
        checkCycle("mis0", 1'b0, 32'h200, 1'b0, 32'h2222_2222);
        // Same cycle: zero-wait ack plus redirect to the top word (data dropped)
        applyStimulus(1'b1, 32'h3333_3333, 1'b0, 1'b1, 32'hFFFF_FFFC);
        checkCycle("mis1", 1'b1, 32'h200, 1'b0, 32'h13);
        checkOutput("mis1.pulse", {31'd0, misaligned}, 32'd1);

        // PC wrap from 0xFFFFFFFC to 0
        applyStimulus(1'b1, 32'h0000_0011, 1'b0, 1'b0, 32'h0);
        checkCycle("wrap0", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h13);
        checkOutput("mis2.pulse", {31'd0, misaligned}, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checkCycle("wrap1", 1'b0, 32'hFFFF_FFFC, 1'b1, 32'h0000_0011);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h300);
        checkCycle("wrap2", 1'b1, 32'h0, 1'b0, 32'h13);

        // Reset mid-FLUSH with an ack arriving during reset
        applyStimulus(1'b1, 32'h4444_4444, 1'b0, 1'b0, 32'h0);
        resetn = 1'b0;
        #1;
        checkCycle("frst", 1'b0, 32'h0, 1'b0, 32'h13);
        checkOutput("frst.pc", id_bus.IF_ID_pc_o, 32'h0);
        @(negedge clk);
        checkCycle("frst.hold", 1'b0, 32'h0, 1'b0, 32'h13);
        resetn = 1'b1;
        #1;
        checkCycle("frst.idle", 1'b0, 32'h0, 1'b0, 32'h13);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkCycle("frst.fetch", 1'b1, 32'h0, 1'b0, 32'h13);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
